// File: rtl/y_axis_packer_pkg.sv
// y_axis_packer_pkg
//   Shared types and sizing helpers for the array-row to AXI-Stream packer.
//   - state_t          : EMPTY (no row held) / FULL (row held, beats pending)
//   - beats_per_row()  : N = C*WY/AXI_WIDTH, the number of output beats per row
//   - beat_idx_w()     : width of the beat index k, $clog2(N) with a floor of 1
//   - N / KW           : the derived constants for the default geometry
package y_axis_packer_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic int beats_per_row(input int c, input int wy, input int aw);
        return (c * wy) / aw;
    endfunction

    // A single-beat row still needs a 1-bit index so the datapath stays uniform.
    function automatic int beat_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int C_DEF         = 8;
    localparam int WY_DEF        = 32;
    localparam int AXI_WIDTH_DEF = 128;
    localparam int N             = beats_per_row(C_DEF, WY_DEF, AXI_WIDTH_DEF);
    localparam int KW            = beat_idx_w(N);

endpackage

// File: rtl/y_axis_packer.sv
// y_axis_packer
//   Takes one row of C elements (WY bits each) per input handshake and
//   serialises it into N = C*WY/AXI_WIDTH output beats, LSB slice first.
//   The input tlast is carried with the row and appears on the final beat.
//   pkt_count counts accepted tlast beats since reset.
//
// Ports
//   clk, rstn                       clock, synchronous active-low reset
//   s_axis_tdata/tvalid/tready/tlast  row input (element c at [c*WY +: WY])
//   m_axis_tdata/tkeep/tvalid/tready/tlast  beat output to the S2MM DMA
//   pkt_count                       32-bit wrapping count of tlast beats
module y_axis_packer
    import y_axis_packer_pkg::*;
#(
    parameter int C         = 8,
    parameter int WY        = 32,
    parameter int AXI_WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [C*WY-1:0]        s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [AXI_WIDTH-1:0]   m_axis_tdata,
    output logic [AXI_WIDTH/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [31:0]            pkt_count
);

    localparam int NB = beats_per_row(C, WY, AXI_WIDTH);
    localparam int KB = beat_idx_w(NB);

    generate
        if (((C * WY) % AXI_WIDTH) != 0 || NB < 1 || (AXI_WIDTH % 8) != 0) begin : g_bad_cfg
            $error("y_axis_packer: C*WY must be a positive multiple of AXI_WIDTH (a multiple of 8)");
        end
    endgenerate

    state_t          r_state;
    logic [KB-1:0]   r_k;
    logic            r_last;
    logic [C*WY-1:0] r_row;
    logic [31:0]     r_pkt;

    logic w_final;
    logic w_in;
    logic w_out;

    assign w_final = (r_k == KB'(NB - 1));

    // Ready is only combinational from m_axis_tready on the final beat, which
    // lets a new row land in the same cycle the old one finishes. Outputs are
    // gated by rstn so nothing is offered while reset is held.
    assign s_axis_tready = !rstn || (r_state == EMPTY) || (w_final && m_axis_tready);
    assign m_axis_tvalid = rstn && (r_state == FULL);
    assign m_axis_tkeep  = {(AXI_WIDTH/8){1'b1}};
    assign m_axis_tlast  = m_axis_tvalid && w_final && r_last;
    assign pkt_count     = r_pkt;

    assign w_in  = s_axis_tvalid && s_axis_tready;
    assign w_out = m_axis_tvalid && m_axis_tready;

    generate
        if (NB == 1) begin : g_one_beat
            assign m_axis_tdata = r_row;
        end else begin : g_multi_beat
            logic [NB-1:0][AXI_WIDTH-1:0] w_beats;
            assign w_beats      = r_row;
            assign m_axis_tdata = w_beats[r_k];
        end
    endgenerate

    // Row payload carries no reset: it is only observed while FULL.
    always_ff @(posedge clk) begin
        if (w_in) begin
            r_row <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= EMPTY;
            r_k     <= '0;
            r_last  <= 1'b0;
            r_pkt   <= '0;
        end else begin
            if (w_out && m_axis_tlast) begin
                r_pkt <= r_pkt + 32'd1;
            end
            case (r_state)
                EMPTY: begin
                    if (w_in) begin
                        r_state <= FULL;
                        r_k     <= '0;
                        r_last  <= s_axis_tlast;
                    end
                end
                FULL: begin
                    if (w_in) begin
                        // Only reachable on the final beat leaving: back-to-back reload.
                        r_k    <= '0;
                        r_last <= s_axis_tlast;
                    end else if (w_out) begin
                        if (w_final) begin
                            r_state <= EMPTY;
                        end else begin
                            r_k <= r_k + KB'(1);
                        end
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

endmodule
